// File: rtl/megarom_pkg.sv
// Shared definitions for the MegaROM cartridge mapper: mode encodings,
// per-mode default bank table and the SCC register window.
package megarom_pkg;

    typedef enum logic [1:0] {
        MODE_ASCII16    = 2'd0,
        MODE_ASCII8     = 2'd1,
        MODE_KONAMI     = 2'd2,
        MODE_KONAMI_SCC = 2'd3
    } mode_t;

    localparam logic [15:0] SCC_WIN_LO   = 16'h9800;
    localparam logic [15:0] SCC_WIN_HI   = 16'h9FFF;
    localparam logic [5:0]  SCC_BANK_KEY = 6'h3F;

    // Konami-style mappers boot with pages 0..3 visible in order; ASCII mappers boot all-zero.
    function automatic logic [7:0] default_bank(input mode_t m, input logic [1:0] idx);
        if (m == MODE_KONAMI || m == MODE_KONAMI_SCC) begin
            return {6'd0, idx};
        end
        return 8'd0;
    endfunction

endpackage

// File: rtl/megarom_bank_decode.sv
// Combinational bank-register write decode: which register (if any) a
// write to addr selects in the given mapper mode.
module megarom_bank_decode
    import megarom_pkg::*;
(
    input  mode_t       mode,
    input  logic [15:0] addr,
    output logic        hit,
    output logic [1:0]  bank_idx
);

    // Register windows are all 2 KB aligned, so the low 11 bits never matter.
    logic w_unused_lo;
    assign w_unused_lo = ^addr[10:0];

    always_comb begin
        hit      = 1'b0;
        bank_idx = 2'd0;
        case (mode)
            MODE_ASCII16: begin
                if (addr[15:11] == 5'b01100) begin
                    hit = 1'b1; bank_idx = 2'd0;
                end else if (addr[15:11] == 5'b01110) begin
                    hit = 1'b1; bank_idx = 2'd1;
                end
            end
            MODE_ASCII8: begin
                if (addr[15:13] == 3'b011) begin
                    hit = 1'b1; bank_idx = addr[12:11];
                end
            end
            MODE_KONAMI: begin
                case (addr[15:13])
                    3'b011:  begin hit = 1'b1; bank_idx = 2'd1; end
                    3'b100:  begin hit = 1'b1; bank_idx = 2'd2; end
                    3'b101:  begin hit = 1'b1; bank_idx = 2'd3; end
                    default: ;
                endcase
            end
            MODE_KONAMI_SCC: begin
                case (addr[15:11])
                    5'b01010: begin hit = 1'b1; bank_idx = 2'd0; end
                    5'b01110: begin hit = 1'b1; bank_idx = 2'd1; end
                    5'b10010: begin hit = 1'b1; bank_idx = 2'd2; end
                    5'b10110: begin hit = 1'b1; bank_idx = 2'd3; end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/megarom_mapper.sv
// MegaROM mapper (ASCII16/ASCII8/Konami/Konami-SCC) translating slot accesses
// in 0x4000-0xBFFF to a flat memory address. SCC window decode under MEGAROM_SCC_EN.
module megarom_mapper
    import megarom_pkg::*;
#(
    parameter int                ADDR_W = 23,
    parameter int                BANK_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       addr,
    input  logic [7:0]        cdin,
    input  logic              merq_n,
    input  logic              iorq_n,
    input  logic              sltsl_n,
    input  logic              m1_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              cart_ena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              scc_sel
);

    logic [3:0][BANK_W-1:0] r_bank;
    logic [3:0][BANK_W-1:0] w_bank_next;
    logic                   r_wr_q;
    mode_t                  r_mode_q;

    mode_t       w_mode_in;
    logic        w_cart_ena;
    logic        w_wr_pulse;
    logic        w_mode_chg;
    logic        w_dec_hit;
    logic [1:0]  w_dec_idx;
    logic        w_unused_strobes;

    assign w_unused_strobes = m1_n & rd_n;

    assign w_mode_in  = mode_t'(mode);
    assign w_cart_ena = (addr[15:14] == 2'b01 || addr[15:14] == 2'b10)
                        && !sltsl_n && !merq_n && iorq_n;
    assign w_wr_pulse = enable & w_cart_ena & ~wr_n & r_wr_q;
    assign w_mode_chg = (w_mode_in != r_mode_q);
    assign cart_ena   = w_cart_ena;

    megarom_bank_decode u_decode (
        .mode     (r_mode_q),
        .addr     (addr),
        .hit      (w_dec_hit),
        .bank_idx (w_dec_idx)
    );

    // A mode change reloads defaults and takes priority over a coincident write.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            assign w_bank_next[gi] =
                w_mode_chg ? BANK_W'(default_bank(w_mode_in, 2'(gi))) :
                (w_wr_pulse && w_dec_hit && w_dec_idx == 2'(gi)) ? cdin[BANK_W-1:0] :
                r_bank[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank   <= '0;
            r_wr_q   <= 1'b1;
            r_mode_q <= MODE_ASCII16;
        end else begin
            r_bank   <= w_bank_next;
            r_wr_q   <= wr_n;
            r_mode_q <= w_mode_in;
        end
    end

    logic [1:0]        w_idx;
    logic [BANK_W-1:0] w_page;
    logic [ADDR_W-1:0] w_offset;

    always_comb begin
        if (r_mode_q == MODE_ASCII16) begin
            w_idx = {1'b0, addr[15]};
        end else begin
            w_idx = addr[14:13] ^ 2'b10;
        end
        w_page = r_bank[w_idx];
        // Plain Konami hard-wires 0x4000-0x5FFF to page 0.
        if (r_mode_q == MODE_KONAMI && w_idx == 2'd0) begin
            w_page = '0;
        end
        if (r_mode_q == MODE_ASCII16) begin
            w_offset = ADDR_W'({w_page, addr[13:0]});
        end else begin
            w_offset = ADDR_W'({w_page, addr[12:0]});
        end
    end

    assign mem_addr = BASE + w_offset;

`ifdef MEGAROM_SCC_EN
    logic [5:0] w_scc_key;
    assign w_scc_key = 6'(r_bank[2]);
    assign scc_sel   = (r_mode_q == MODE_KONAMI_SCC) && w_cart_ena
                       && (addr >= SCC_WIN_LO) && (addr <= SCC_WIN_HI)
                       && (w_scc_key == SCC_BANK_KEY);
`else
    assign scc_sel = 1'b0;
`endif

endmodule

// File: tb/tb_megarom_mapper.sv
// Scoreboard bench for megarom_mapper: directed bus reads/writes push expected
// outputs; a negedge monitor pops and compares while a read is presented.
module tb_megarom_mapper;

`ifdef MEGAROM_SCC_EN
    localparam bit SCC_ON = 1'b1;
`else
    localparam bit SCC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  cdin = 8'h00;
    logic        merq_n = 1'b1;
    logic        iorq_n = 1'b1;
    logic        sltsl_n = 1'b1;
    logic        m1_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        cart_ena;
    logic [22:0] mem_addr;
    logic        scc_sel;

    megarom_mapper #(.ADDR_W(23), .BANK_W(8), .BASE(23'h000000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .cdin     (cdin),
        .merq_n   (merq_n),
        .iorq_n   (iorq_n),
        .sltsl_n  (sltsl_n),
        .m1_n     (m1_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .enable   (enable),
        .mode     (mode),
        .cart_ena (cart_ena),
        .mem_addr (mem_addr),
        .scc_sel  (scc_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [22:0] exp_addr;
        bit          chk_addr;
        bit          exp_ena;
        bit          exp_scc;
    } exp_t;

    exp_t sb_q[$];
    bit   sample_req = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(negedge clk) begin
        if (sample_req) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (cart_ena !== e.exp_ena) begin
                    n_errors++;
                    $display("FAIL %s.cart_ena: got %0b expected %0b", e.name, cart_ena, e.exp_ena);
                end
                n_checks++;
                if (scc_sel !== e.exp_scc) begin
                    n_errors++;
                    $display("FAIL %s.scc_sel: got %0b expected %0b", e.name, scc_sel, e.exp_scc);
                end
                if (e.chk_addr) begin
                    n_checks++;
                    if (mem_addr !== e.exp_addr) begin
                        n_errors++;
                        $display("FAIL %s.mem_addr: got 0x%06h expected 0x%06h", e.name, mem_addr, e.exp_addr);
                    end
                end
                $display("read %-12s addr=0x%04h mem_addr=0x%06h cart_ena=%0b scc_sel=%0b",
                         e.name, addr, mem_addr, cart_ena, scc_sel);
            end
        end
    end

    task automatic do_read(input string nm, input logic [15:0] a, input logic slt_n_v,
                           input logic iorq_v, input bit ca, input logic [22:0] ea,
                           input bit ee, input bit es);
        exp_t e;
        @(posedge clk); #1;
        addr    = a;
        sltsl_n = slt_n_v;
        iorq_n  = iorq_v;
        merq_n  = 1'b0;
        rd_n    = 1'b0;
        e = '{nm, ea, ca, ee, es};
        sb_q.push_back(e);
        sample_req = 1'b1;
        @(posedge clk); #1;
        sample_req = 1'b0;
        rd_n    = 1'b1;
        merq_n  = 1'b1;
        sltsl_n = 1'b1;
        iorq_n  = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [15:0] a, input logic [22:0] ea, input bit es);
        do_read(nm, a, 1'b0, 1'b1, 1'b1, ea, 1'b1, es);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                             input logic [7:0] d2, input bit en, input bit slt);
        @(posedge clk); #1;
        addr    = a;
        cdin    = d;
        enable  = en;
        sltsl_n = ~slt;
        merq_n  = 1'b0;
        wr_n    = 1'b0;
        @(posedge clk); #1;
        cdin = d2;
        for (int k = 1; k < hold; k++) begin
            @(posedge clk); #1;
        end
        wr_n    = 1'b1;
        merq_n  = 1'b1;
        sltsl_n = 1'b1;
        enable  = 1'b1;
        $display("write addr=0x%04h data=0x%02h hold=%0d enable=%0b slot=%0b", a, d, hold, en, slt);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk); #1;
        mode = m;
        $display("mode -> %0d", m);
    endtask

    initial begin
        // Reset state (still in reset)
        rd("rst_8123", 16'h8123, 23'h000123, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ASCII16
        rd("a16_8123", 16'h8123, 23'h000123, 1'b0);
        bus_write(16'h7000, 8'h05, 1, 8'h00, 1'b1, 1'b1);
        rd("a16_8123_b5", 16'h8123, 23'h014123, 1'b0);
        rd("a16_4123", 16'h4123, 23'h000123, 1'b0);
        do_read("ena_3FFF", 16'h3FFF, 1'b0, 1'b1, 1'b0, 23'h0, 1'b0, 1'b0);
        do_read("ena_C000", 16'hC000, 1'b0, 1'b1, 1'b0, 23'h0, 1'b0, 1'b0);

        // ASCII8
        set_mode(2'd1);
        bus_write(16'h6800, 8'h03, 1, 8'h00, 1'b1, 1'b1);
        rd("a8_6010", 16'h6010, 23'h006010, 1'b0);
        rd("a8_4010", 16'h4010, 23'h000010, 1'b0);
        bus_write(16'h7800, 8'h11, 1, 8'h00, 1'b1, 1'b1);
        rd("a8_A005", 16'h A005, 23'h022005, 1'b0);

        // Konami: defaults visible one cycle after the switch
        set_mode(2'd2);
        rd("kon_A000", 16'hA000, 23'h006000, 1'b0);
        rd("kon_8000", 16'h8000, 23'h004000, 1'b0);
        rd("kon_6000", 16'h6000, 23'h002000, 1'b0);
        bus_write(16'h4000, 8'h07, 1, 8'h00, 1'b1, 1'b1);
        rd("kon_4000", 16'h4000, 23'h000000, 1'b0);
        bus_write(16'h6000, 8'h05, 1, 8'h00, 1'b1, 1'b1);
        rd("kon_7FFF", 16'h7FFF, 23'h00BFFF, 1'b0);

        // Long write strobe: only the first edge counts
        bus_write(16'hA000, 8'h02, 5, 8'h07, 1'b1, 1'b1);
        rd("hold_A010", 16'hA010, 23'h004010, 1'b0);

        // Konami-SCC
        set_mode(2'd3);
        bus_write(16'h9000, 8'h3F, 1, 8'h00, 1'b1, 1'b1);
        rd("scc_9800", 16'h9800, 23'h07F800, SCC_ON);
        rd("scc_9000", 16'h9000, 23'h07F000, 1'b0);
        bus_write(16'h5000, 8'h04, 1, 8'h00, 1'b1, 1'b1);
        rd("scc_4100", 16'h4100, 23'h008100, 1'b0);

        // Qualified writes and cart_ena equation
        set_mode(2'd1);
        bus_write(16'h6000, 8'h09, 1, 8'h00, 1'b0, 1'b1);
        rd("en0_4000", 16'h4000, 23'h000000, 1'b0);
        bus_write(16'h6000, 8'h09, 1, 8'h00, 1'b1, 1'b0);
        rd("slt1_4000", 16'h4000, 23'h000000, 1'b0);
        do_read("ena_slt1", 16'h6000, 1'b1, 1'b1, 1'b0, 23'h0, 1'b0, 1'b0);
        do_read("ena_iorq", 16'h6000, 1'b0, 1'b0, 1'b0, 23'h0, 1'b0, 1'b0);
        rd("a8_BFFF", 16'hBFFF, 23'h001FFF, 1'b0);
        bus_write(16'h6000, 8'h0A, 1, 8'h00, 1'b1, 1'b1);
        rd("a8_4001", 16'h4001, 23'h014001, 1'b0);

        // Reset asserted mid-write
        @(posedge clk); #1;
        addr = 16'h6800; cdin = 8'h0B; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        wr_n = 1'b1; merq_n = 1'b1; sltsl_n = 1'b1;
        $display("reset asserted mid-write");
        rd("rst_4001", 16'h4001, 23'h000001, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd("post_6800", 16'h6800, 23'h000800, 1'b0);

        // Write coincident with mode change is dropped
        @(posedge clk); #1;
        mode = 2'd0; addr = 16'h7000; cdin = 8'h09; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1; merq_n = 1'b1; sltsl_n = 1'b1;
        $display("write addr=0x7000 data=0x09 with mode change");
        rd("drop_8123", 16'h8123, 23'h000123, 1'b0);
        bus_write(16'h7000, 8'h09, 1, 8'h00, 1'b1, 1'b1);
        rd("a16_8123_b9", 16'h8123, 23'h024123, 1'b0);

        @(posedge clk); #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/megarom_mapper.md
Name: megarom_mapper

Overview:
Parametrised MegaROM mapper for the cartridge slot, generalising the fixed 16 KB single-page BIOS mapper. It supports four runtime-selectable mapper modes: ASCII16, ASCII8, Konami and Konami-SCC. It provides up to four bank registers with 8 KB or 16 KB granularity and edge-qualified register writes. It translates Z80 slot accesses in 0x4000-0xBFFF into a flat external-memory address for the SDRAM/flash controller.

Parameters:
ADDR_W, 23, width of mem_addr.
BANK_W, 8, bank register width (1..8); cdin[BANK_W-1:0] is stored.
BASE, 23'h000000, image offset added to every translated address.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr  in  16  Z80 address
cdin  in  8  Z80 data bus (write data)
merq_n  in  1  memory request, active low
iorq_n  in  1  I/O request, active low
sltsl_n  in  1  slot select, active low
m1_n  in  1  opcode fetch, unused except for lint
rd_n  in  1  read strobe, active low
wr_n  in  1  write strobe, active low
enable  in  1  mapper enabled; when low, bank registers hold
mode  in  2  0=ASCII16, 1=ASCII8, 2=KONAMI, 3=KONAMI_SCC
cart_ena  out  1  slot access in 0x4000-0xBFFF
mem_addr  out  ADDR_W  translated address
scc_sel  out  1  SCC register window hit

Behaviour:
- cart_ena is combinational: addr[15:14] is 01 or 10, sltsl_n=0, merq_n=0, iorq_n=1.
- State:
  - bank[0..3], each BANK_W bits.
  - wr_q, the previous wr_n sample.
  - mode_q.
- Reset values: bank[0..3]=0, wr_q=1, mode_q=0 (ASCII16). Outputs are combinational from state, so after reset mem_addr=BASE+translated(addr).
- Write strobe: wr_pulse = enable & cart_ena & ~wr_n & wr_q.
  - A bus write updates exactly one register, once, on the first rising clk edge where wr_n is sampled low.
  - wr_q <= wr_n every cycle.
- Register write decode, applied on wr_pulse with bank[i] <= cdin[BANK_W-1:0]:
  - ASCII16: 6000-67FF -> bank0; 7000-77FF -> bank1.
  - ASCII8: 6000-67FF -> b0; 6800-6FFF -> b1; 7000-77FF -> b2; 7800-7FFF -> b3.
  - KONAMI: 6000-7FFF -> b1; 8000-9FFF -> b2; A000-BFFF -> b3. bank0 is fixed.
  - KONAMI_SCC: 5000-57FF -> b0; 7000-77FF -> b1; 9000-97FF -> b2; B000-B7FF -> b3.
  - Writes to any other address are ignored.
- Mode change: mode_q <= mode every cycle. When mode != mode_q, the next edge loads the new mode's defaults and any coincident wr_pulse is dropped.
  - ASCII modes default to all 0.
  - Konami modes default to b0..b3 = 0,1,2,3.
  - If mode is Konami at reset release, the reload occurs on the first clock.
- KONAMI with bank0: bank0 is ignored for translation; 4000-5FFF always maps to page 0.
- Translation:
  - 8 KB modes: idx = addr[14:13] XOR 2'b10 (4000->0, 6000->1, 8000->2, A000->3). mem_addr = BASE + {bank[idx], addr[12:0]}.
  - ASCII16: idx = addr[15]. mem_addr = BASE + {bank[idx], addr[13:0]}.
  - Results are zero-extended and truncated to ADDR_W; wrap-around modulo 2^ADDR_W is permitted.
- Accesses outside 4000-BFFF: mem_addr is don't-care and cart_ena=0.
- Asynchronous reset mid-access clears all state immediately. The next write requires a fresh wr_n high->low.

Optional Feature:
Macro MEGAROM_SCC_EN.
- Defined: scc_sel=1 when mode=KONAMI_SCC, cart_ena=1, addr in 9800-9FFF and bank[2][5:0]=6'h3F. This is combinational.
- Undefined: scc_sel is tied 0 and no SCC logic is synthesised.

Decomposition:
- Package megarom_pkg holds:
  - mode encodings MODE_ASCII16, MODE_ASCII8, MODE_KONAMI, MODE_KONAMI_SCC.
  - per-mode default bank table.
  - SCC window constants.
- Sub-module megarom_bank_decode: combinational (mode, addr) -> {hit, bank_index[1:0]} for register writes.

Test Plan:
1. Reset, mode=ASCII16, read 0x8123 -> mem_addr=0x000123. Write 0x05 to 0x7000, then read 0x8123 -> mem_addr=0x014123.
2. ASCII8: write 0x03 to 0x6800, then read 0x6010 -> mem_addr=0x006010. Read 0x4010 still gives 0x000010.
3. mode switched 0->2, then KONAMI: b1..b3 become 1,2,3 one cycle later. Read 0xA000 -> 0x006000. A write to 0x4000 changes nothing.
4. Hold wr_n low for 5 clocks with cdin changing 0x02 then 0x07 after the first edge -> bank register equals 0x02.
5. KONAMI_SCC with MEGAROM_SCC_EN: write 0x3F to 0x9000, then read 0x9800 -> scc_sel=1. Read 0x9000 -> scc_sel=0. Without the macro -> scc_sel=0.
6. enable=0 or sltsl_n=1 during a write to 0x6000 -> registers unchanged and cart_ena follows its equation. Assert reset_n low mid-write -> banks return to 0 immediately.
